// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path and the frame buffer writer.
package cam_pkg;

  localparam int CAM_LINE_PIXELS = 640;
  localparam int CAM_COL_WIDTH   = 10;
  localparam int CAM_ROW_WIDTH   = 9;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    WAIT_START,
    ACTIVE
  } cam_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a third aligned stage and registered rise/fall pulses.
module cam_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  // level, rise and fall all update on the same edge, so they stay aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      s1    <= d;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// Oversamples the parallel camera bus, packs byte pairs into RGB565 pixels
// and presents them on a single-entry valid/ready output register.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int LINE_PIXELS = CAM_LINE_PIXELS,
  parameter int COL_WIDTH   = CAM_COL_WIDTH,
  parameter int ROW_WIDTH   = CAM_ROW_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cam_pclk,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_data,
  output logic [15:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 frame_done,
  output logic [ROW_WIDTH-1:0] line_count,
  output logic                 overflow,
  input  logic                 clear_ovf,
  output cam_state_e           fsm_state
);

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(LINE_PIXELS - 1);

  logic       pclk_level, pclk_rise, pclk_fall;
  logic       vs_level, vs_rise, vs_fall;
  logic       href_level, href_rise, href_fall;
  logic [7:0] data_level, data_rise, data_fall;
  logic       unused_edges;

  cam_sync_edge #(.W(1)) u_sync_pclk (.clk(clk), .reset(reset), .d(cam_pclk),
    .level(pclk_level), .rise(pclk_rise), .fall(pclk_fall));
  cam_sync_edge #(.W(1)) u_sync_vsync (.clk(clk), .reset(reset), .d(cam_vsync),
    .level(vs_level), .rise(vs_rise), .fall(vs_fall));
  cam_sync_edge #(.W(1)) u_sync_href (.clk(clk), .reset(reset), .d(cam_href),
    .level(href_level), .rise(href_rise), .fall(href_fall));
  cam_sync_edge #(.W(8)) u_sync_data (.clk(clk), .reset(reset), .d(cam_data),
    .level(data_level), .rise(data_rise), .fall(data_fall));

  assign unused_edges = ^{pclk_level, pclk_fall, href_rise, data_rise, data_fall};

  cam_state_e state_q, state_d;
  logic       start_frame;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE:       if (enable) state_d = WAIT_VS;
      WAIT_VS:    if (vs_level) state_d = WAIT_START;
      WAIT_START: if (vs_fall) begin
        start_frame = 1'b1;
        state_d     = ACTIVE;
      end
      ACTIVE:     if (vs_rise) begin
        frame_done = 1'b1;
        state_d    = enable ? WAIT_START : IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  logic                 phase;
  logic [7:0]           hi_byte;
  logic [COL_WIDTH-1:0] col;
  logic                 sof_pending;
  logic                 byte_tick, pix_form, line_end, load, drop;

  assign byte_tick = (state_q == ACTIVE) && pclk_rise && href_level;
  assign pix_form  = byte_tick && phase;
  assign line_end  = (state_q == ACTIVE) && href_fall;

  // pix_valid/pix_ready: a pixel transfers in any cycle where both are high;
  // once pix_valid rises, it and the payload hold until that transfer cycle.
  assign load = pix_form && (!pix_valid || pix_ready);
  assign drop = pix_form && pix_valid && !pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase       <= 1'b0;
      hi_byte     <= '0;
      col         <= '0;
      sof_pending <= 1'b0;
      line_count  <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (start_frame) begin
        line_count  <= '0;
        col         <= '0;
        phase       <= 1'b0;
        sof_pending <= 1'b1;
      end else if (line_end) begin
        // a line with only an odd leftover byte still counts; the byte is discarded
        if (col != '0 || phase) line_count <= line_count + 1'b1;
        col   <= '0;
        phase <= 1'b0;
      end else if (byte_tick) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= data_level;
        end else begin
          sof_pending <= 1'b0;
          if (col != COL_LAST) col <= col + 1'b1;
        end
      end

      if (load) begin
        pix_valid <= 1'b1;
        pix_data  <= {hi_byte, data_level};
        pix_sof   <= sof_pending;
        pix_eol   <= (col == COL_LAST);
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end

      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a pixel scoreboard.
module tb_cam_pixel_capture;
  import cam_pkg::*;

  localparam int LP = 4;
  localparam int CW = 2;
  localparam int RW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = '0;
  logic          pix_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof, pix_eol, frame_done, overflow;
  logic [RW-1:0] line_count;
  cam_state_e    fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;

  logic [17:0] exp_q[$];
  logic [17:0] exp_pix;
  logic [7:0]  line_bytes [16];
  bit          sof_m = 1'b0;
  int          col_m = 0;

  cam_pixel_capture #(.LINE_PIXELS(LP), .COL_WIDTH(CW), .ROW_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .line_count(line_count), .overflow(overflow), .clear_ovf(clear_ovf),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // scoreboard: pop one expected pixel per accepted transfer
  always begin
    @(negedge clk);
    #2;
    if (reset && frame_done) fd_count++;
    if (reset && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("pixel_unexpected", {14'b0, pix_sof, pix_eol, pix_data}, 32'hffff_ffff);
      end else begin
        exp_pix = exp_q.pop_front();
        check("pixel", {14'b0, pix_sof, pix_eol, pix_data}, {14'b0, exp_pix});
      end
    end
  end

  // driver tasks: each starts and ends just after a falling clk edge
  task automatic send_byte(input logic [7:0] b, input bit lat_chk);
    cam_pclk = 1'b0;
    cam_data = b;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    if (lat_chk) begin
      repeat (3) @(posedge clk);
      #1 check("latency_3clk_not_valid", pix_valid, 0);
      @(posedge clk);
      #1 check("latency_4clk_valid", pix_valid, 1);
      @(negedge clk);
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_line(input int nbytes, input int n_push, input int lat_idx);
    int pix_idx;
    logic [7:0] hi;
    pix_idx  = 0;
    hi       = '0;
    cam_href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 1) begin
        if (pix_idx < n_push) exp_q.push_back({sof_m, (col_m == LP - 1), hi, line_bytes[i]});
        sof_m = 1'b0;
        if (col_m != LP - 1) col_m++;
        pix_idx++;
      end else begin
        hi = line_bytes[i];
      end
      send_byte(line_bytes[i], i == lat_idx);
    end
    cam_href = 1'b0;
    col_m    = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
    cam_vsync = 1'b0;
    sof_m     = 1'b1;
    col_m     = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end(input bit exp_done);
    cam_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("frame_done_at_3clk", frame_done, exp_done);
    @(posedge clk);
    #1 check("frame_done_one_cycle", frame_done, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_sof", pix_sof, 0);
    check("rst_pix_eol", pix_eol, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_count", line_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", fsm_state, IDLE);
    reset = 1'b1;
    @(negedge clk);

    // one line of four bytes, with output latency check
    enable    = 1'b1;
    pix_ready = 1'b1;
    frame_start();
    check("t1_state_active", fsm_state, ACTIVE);
    line_bytes[0] = 8'h12; line_bytes[1] = 8'h34;
    line_bytes[2] = 8'h56; line_bytes[3] = 8'h78;
    send_line(4, 1000, 1);
    check("t1_line_count", line_count, 1);
    drain();
    frame_end(1'b1);
    check("t1_state_after_frame", fsm_state, WAIT_START);
    check("t1_line_count_held", line_count, 1);

    // two full lines: eol on the last column of each
    frame_start();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 8; i++) line_bytes[i] = 8'($urandom_range(0, 255));
      send_line(8, 1000, -1);
    end
    frame_end(1'b1);
    check("t2_line_count", line_count, 2);
    check("t2_frame_done_count", fd_count, 2);
    drain();

    // stalled consumer: first pixel held, the rest dropped
    frame_start();
    pix_ready = 1'b0;
    line_bytes[0] = 8'hAA; line_bytes[1] = 8'hBB; line_bytes[2] = 8'hCC;
    line_bytes[3] = 8'hDD; line_bytes[4] = 8'hEE; line_bytes[5] = 8'hFF;
    send_line(6, 1, -1);
    check("t3_overflow_set", overflow, 1);
    check("t3_held_valid", pix_valid, 1);
    check("t3_held_data", pix_data, 16'hAABB);
    check("t3_held_sof", pix_sof, 1);
    check("t3_line_count", line_count, 1);
    pix_ready = 1'b1;
    drain();
    check("t3_overflow_sticky", overflow, 1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("t3_overflow_cleared", overflow, 0);

    // odd leftover byte discarded, next line restarts at column 0
    line_bytes[0] = 8'h01; line_bytes[1] = 8'h02; line_bytes[2] = 8'h03;
    send_line(3, 1000, -1);
    for (int i = 0; i < 8; i++) line_bytes[i] = 8'((i + 1) * 16);
    send_line(8, 1000, -1);
    drain();
    check("t4_line_count", line_count, 3);

    // enable dropped mid-frame: frame completes, then IDLE
    enable = 1'b0;
    line_bytes[0] = 8'h5A; line_bytes[1] = 8'hA5;
    line_bytes[2] = 8'h3C; line_bytes[3] = 8'hC3;
    send_line(4, 1000, -1);
    drain();
    frame_end(1'b1);
    check("t5_state_idle", fsm_state, IDLE);
    check("t5_line_count", line_count, 4);
    check("t5_frame_done_count", fd_count, 3);
    frame_start();
    send_line(4, 0, -1);
    frame_end(1'b0);
    check("t5_ignored_state", fsm_state, IDLE);
    check("t5_ignored_line_count", line_count, 4);
    check("t5_ignored_frame_done_count", fd_count, 3);

    // reset mid-line with a pixel pending
    enable    = 1'b1;
    pix_ready = 1'b0;
    frame_start();
    cam_href = 1'b1;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_pending_valid", pix_valid, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_pix_valid", pix_valid, 0);
    check("t6_rst_pix_data", pix_data, 0);
    check("t6_rst_pix_sof", pix_sof, 0);
    check("t6_rst_line_count", line_count, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_state", fsm_state, IDLE);
    @(negedge clk);
    reset     = 1'b1;
    pix_ready = 1'b1;
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    cam_href = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_wait_vs_state", fsm_state, WAIT_VS);
    check("t6_no_pixel", pix_valid, 0);
    frame_start();
    line_bytes[0] = 8'hE1; line_bytes[1] = 8'hE2;
    line_bytes[2] = 8'hE3; line_bytes[3] = 8'hE4;
    send_line(4, 1000, -1);
    drain();
    check("t6_line_count", line_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
